// File: rtl/isa_ddr_reader_pkg.sv
// Shared defaults and FSM encoding for the instruction-fetch path
// (instruction cache, DDR reader, DDR interface).
package isa_ddr_reader_pkg;

  localparam int DDR_ADDR_WIDTH_DEF = 28;
  localparam int DDR_DATA_WIDTH_DEF = 64;
  localparam int ISA_WIDTH_DEF      = 30;
  localparam int MAX_BURST_DEF      = 64;
  localparam int LEN_W              = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/isa_ddr_reader_if.sv
// DDR read-burst channel: request/ack handshake plus beat data return.
interface isa_ddr_reader_if #(
  parameter int ADDR_W = isa_ddr_reader_pkg::DDR_ADDR_WIDTH_DEF,
  parameter int DATA_W = isa_ddr_reader_pkg::DDR_DATA_WIDTH_DEF
);
  import isa_ddr_reader_pkg::*;

  logic              ddr_rd_req;
  logic [ADDR_W-1:0] ddr_rd_addr;
  logic [LEN_W-1:0]  ddr_rd_len;
  logic              ddr_rd_ack;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_data_valid;
  logic              ddr_rd_finish;

  modport master (
    output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    input  ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid, ddr_rd_finish
  );

  modport slave (
    input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    output ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid, ddr_rd_finish
  );

endinterface

// File: rtl/isa_ddr_reader.sv
// Fetches a run of instructions from DDR in bursts of up to MAX_BURST beats
// and streams them to the instruction cache, one instruction per beat.
module isa_ddr_reader
  import isa_ddr_reader_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = DDR_ADDR_WIDTH_DEF,
  parameter int DDR_DATA_WIDTH = DDR_DATA_WIDTH_DEF,
  parameter int ISA_WIDTH      = ISA_WIDTH_DEF,
  parameter int MAX_BURST      = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ISA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  input  logic [LEN_W-1:0]          isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [LEN_W-1:0]          rd_cnt_isa,
  output logic                      rd_burst_data_valid,
  output logic                      isa_read_done,
  isa_ddr_reader_if.master          ddr
);

  localparam logic [LEN_W-1:0] MAXB       = LEN_W'(MAX_BURST);
  localparam int               BEAT_BYTES = DDR_DATA_WIDTH / 8;

  rd_state_e                 r_state;
  logic [DDR_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_rem;
  logic [LEN_W-1:0]          r_burst_len;
  logic [LEN_W-1:0]          r_cnt;
  logic [ISA_WIDTH-1:0]      r_instr;
  logic                      r_strobe;
  logic                      r_req;
  logic                      r_done;

  logic [LEN_W-1:0]          w_first_burst;
  logic [LEN_W-1:0]          w_rem_next;
  logic [LEN_W-1:0]          w_next_burst;
  logic [DDR_ADDR_WIDTH-1:0] w_step;
  logic [DDR_ADDR_WIDTH-1:0] w_addr_next;
  logic                      w_take;
  logic                      w_unused_data;

  assign w_first_burst = (isa_read_len > MAXB) ? MAXB : isa_read_len;
  assign w_rem_next    = r_rem - r_burst_len;
  assign w_next_burst  = (w_rem_next > MAXB) ? MAXB : w_rem_next;
  // Address advance truncates to DDR_ADDR_WIDTH, so bursts wrap at the top of memory.
  assign w_step        = DDR_ADDR_WIDTH'(r_burst_len) * DDR_ADDR_WIDTH'(BEAT_BYTES);
  assign w_addr_next   = r_addr + w_step;
  // Beats past the requested length (controller over-delivery) are dropped.
  assign w_take        = (r_state == ST_DATA) && ddr.ddr_rd_data_valid && (r_cnt < r_len);
  assign w_unused_data = ^ddr.ddr_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_burst_len <= '0;
      r_cnt       <= '0;
      r_instr     <= '0;
      r_strobe    <= 1'b0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ISA_read_req) begin
            r_addr      <= ISA_read_addr;
            r_len       <= isa_read_len;
            r_rem       <= isa_read_len;
            r_cnt       <= '0;
            r_burst_len <= w_first_burst;
            if (isa_read_len != '0) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (ddr.ddr_rd_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_take) begin
            r_instr  <= ddr.ddr_rd_data[ISA_WIDTH-1:0];
            r_strobe <= 1'b1;
            r_cnt    <= r_cnt + LEN_W'(1);
          end
          // A beat coinciding with finish is taken above in the same edge.
          if (ddr.ddr_rd_finish) begin
            r_rem       <= w_rem_next;
            r_addr      <= w_addr_next;
            r_burst_len <= w_next_burst;
            if ((w_rem_next != '0) && ISA_read_req) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!ISA_read_req) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ddr.ddr_rd_req       = r_req;
  assign ddr.ddr_rd_addr      = r_addr;
  assign ddr.ddr_rd_len       = r_burst_len;
  assign instruction_to_cache = r_instr;
  assign rd_cnt_isa           = r_cnt;
  assign rd_burst_data_valid  = r_strobe;
  assign isa_read_done        = r_done;

endmodule

// File: tb/tb_isa_ddr_reader.sv
// Randomized bench for isa_ddr_reader: the bench acts as DDR controller and
// predicts bursts, strobes and counts from length/address arithmetic.
module tb_isa_ddr_reader;

  localparam int AW = 28;
  localparam int DW = 64;
  localparam int IW = 30;
  localparam int MB = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ISA_read_req = 1'b0;
  logic [AW-1:0] ISA_read_addr = '0;
  logic [9:0]    isa_read_len = '0;
  logic [IW-1:0] instruction_to_cache;
  logic [9:0]    rd_cnt_isa;
  logic          rd_burst_data_valid;
  logic          isa_read_done;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  isa_ddr_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ddr_bus ();

  isa_ddr_reader #(
    .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .ISA_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
    .instruction_to_cache(instruction_to_cache), .rd_cnt_isa(rd_cnt_isa),
    .rd_burst_data_valid(rd_burst_data_valid), .isa_read_done(isa_read_done),
    .ddr(ddr_bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rd_burst_data_valid === 1'b1) strobe_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    ddr_bus.ddr_rd_ack = 1'b0;
    ddr_bus.ddr_rd_data = '0;
    ddr_bus.ddr_rd_data_valid = 1'b0;
    ddr_bus.ddr_rd_finish = 1'b0;
  endtask

  // One full transaction; the bench plays the DDR controller.
  task automatic run_txn(input logic [AW-1:0] a, input int n, input int ack_dly,
                         input bit same_fin, input int extra, input bit drop,
                         input int gap_pct, input string name);
    int rem = n;
    int idx = 0;
    int exp_total = 0;
    int bl, nb, to, sc0, exp_cnt;
    bit exp_stb, last;
    logic [AW-1:0] cur = a;
    logic [DW-1:0] d;
    sc0 = strobe_cnt;
    ISA_read_addr = a;
    isa_read_len = 10'(n);
    ISA_read_req = 1'b1;
    if (n == 0) tick();
    while (rem > 0) begin
      bl = (rem > MB) ? MB : rem;
      to = 0;
      while (ddr_bus.ddr_rd_req !== 1'b1 && to < 20) begin tick(); to++; end
      checks++;
      if (ddr_bus.ddr_rd_req !== 1'b1) begin
        errors++;
        $display("FAIL %s req_timeout got req=%b exp 1", name, ddr_bus.ddr_rd_req);
        ISA_read_req = 1'b0;
        repeat (3) tick();
        return;
      end
      checks++;
      if (ddr_bus.ddr_rd_addr !== cur || ddr_bus.ddr_rd_len !== 10'(bl)) begin
        errors++;
        $display("FAIL %s burst got addr=%0h len=%0d exp addr=%0h len=%0d",
                 name, ddr_bus.ddr_rd_addr, ddr_bus.ddr_rd_len, cur, bl);
      end
      for (int k = 0; k < ack_dly; k++) begin
        tick();
        checks++;
        if (ddr_bus.ddr_rd_req !== 1'b1 || ddr_bus.ddr_rd_addr !== cur || ddr_bus.ddr_rd_len !== 10'(bl)) begin
          errors++;
          $display("FAIL %s hold_wait%0d got req=%b addr=%0h len=%0d exp req=1 addr=%0h len=%0d",
                   name, k, ddr_bus.ddr_rd_req, ddr_bus.ddr_rd_addr, ddr_bus.ddr_rd_len, cur, bl);
        end
      end
      ddr_bus.ddr_rd_ack = 1'b1;
      tick();
      ddr_bus.ddr_rd_ack = 1'b0;
      checks++;
      if (ddr_bus.ddr_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL %s req_drop got req=%b exp 0", name, ddr_bus.ddr_rd_req);
      end
      if (drop) ISA_read_req = 1'b0;
      last = (rem == bl) || drop;
      nb = bl + ((rem == bl) ? extra : 0);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 99) < gap_pct) tick();
        d = {$urandom, $urandom};
        ddr_bus.ddr_rd_data = d;
        ddr_bus.ddr_rd_data_valid = 1'b1;
        ddr_bus.ddr_rd_finish = same_fin && (i == nb - 1);
        tick();
        ddr_bus.ddr_rd_data_valid = 1'b0;
        ddr_bus.ddr_rd_finish = 1'b0;
        exp_stb = (idx < n);
        exp_cnt = (idx + 1 < n) ? idx + 1 : n;
        if (exp_stb) exp_total++;
        idx++;
        checks++;
        if (rd_burst_data_valid !== exp_stb || rd_cnt_isa !== 10'(exp_cnt) ||
            (exp_stb && instruction_to_cache !== d[IW-1:0])) begin
          errors++;
          $display("FAIL %s beat%0d got stb=%b cnt=%0d instr=%0h exp stb=%b cnt=%0d instr=%0h",
                   name, idx - 1, rd_burst_data_valid, rd_cnt_isa, instruction_to_cache,
                   exp_stb, exp_cnt, d[IW-1:0]);
        end
      end
      if (!same_fin) begin
        ddr_bus.ddr_rd_finish = 1'b1;
        tick();
        ddr_bus.ddr_rd_finish = 1'b0;
      end
      rem -= bl;
      cur = cur + AW'(bl * (DW / 8));
      if (last) break;
    end
    checks++;
    if (isa_read_done !== 1'b1 || ddr_bus.ddr_rd_req !== 1'b0 || rd_cnt_isa !== 10'(exp_total)) begin
      errors++;
      $display("FAIL %s done got done=%b req=%b cnt=%0d exp done=1 req=0 cnt=%0d",
               name, isa_read_done, ddr_bus.ddr_rd_req, rd_cnt_isa, exp_total);
    end
    if (!drop) begin
      repeat (3) tick();
      checks++;
      if (isa_read_done !== 1'b1 || ddr_bus.ddr_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL %s done_hold got done=%b req=%b exp done=1 req=0",
                 name, isa_read_done, ddr_bus.ddr_rd_req);
      end
      ISA_read_req = 1'b0;
    end
    tick();
    tick();
    checks++;
    if (isa_read_done !== 1'b0 || rd_cnt_isa !== 10'(exp_total) || strobe_cnt - sc0 !== exp_total) begin
      errors++;
      $display("FAIL %s idle got done=%b cnt=%0d strobes=%0d exp done=0 cnt=%0d strobes=%0d",
               name, isa_read_done, rd_cnt_isa, strobe_cnt - sc0, exp_total, exp_total);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_idle();
    repeat (2) tick();
    checks++;
    if (ddr_bus.ddr_rd_req !== 1'b0 || ddr_bus.ddr_rd_addr !== '0 || ddr_bus.ddr_rd_len !== '0 ||
        instruction_to_cache !== '0 || rd_cnt_isa !== '0 || rd_burst_data_valid !== 1'b0 ||
        isa_read_done !== 1'b0) begin
      errors++;
      $display("FAIL reset got req=%b addr=%0h len=%0d instr=%0h cnt=%0d stb=%b done=%b exp all 0",
               ddr_bus.ddr_rd_req, ddr_bus.ddr_rd_addr, ddr_bus.ddr_rd_len, instruction_to_cache,
               rd_cnt_isa, rd_burst_data_valid, isa_read_done);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();      run_txn(28'h40, 5, 0, 1'b0, 0, 1'b0, 0, "single"); endtask
  task automatic test_multi_burst(); run_txn(28'h0, 128, 1, 1'b0, 0, 1'b0, 15, "multi"); endtask
  task automatic test_ack_delay();   run_txn(28'h1000, 20, 7, 1'b0, 0, 1'b0, 0, "ack_delay"); endtask
  task automatic test_same_cycle();  run_txn(28'h88, 9, 0, 1'b1, 0, 1'b0, 0, "same_cycle"); endtask
  task automatic test_overrun();     run_txn(28'h100, 3, 0, 1'b1, 2, 1'b0, 0, "overrun"); endtask
  task automatic test_len0();        run_txn(28'h40, 0, 0, 1'b0, 0, 1'b0, 0, "len0"); endtask
  task automatic test_drop();        run_txn(28'h0, 150, 2, 1'b0, 0, 1'b1, 0, "drop"); endtask
  task automatic test_wrap();        run_txn(28'hFFFFFF0, 70, 0, 1'b0, 0, 1'b0, 0, "wrap"); endtask

  task automatic test_reset_mid();
    int to = 0;
    int sc;
    ISA_read_addr = 28'h800;
    isa_read_len = 10'd64;
    ISA_read_req = 1'b1;
    while (ddr_bus.ddr_rd_req !== 1'b1 && to < 20) begin tick(); to++; end
    ddr_bus.ddr_rd_ack = 1'b1;
    tick();
    ddr_bus.ddr_rd_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ddr_bus.ddr_rd_data = {$urandom, $urandom};
      ddr_bus.ddr_rd_data_valid = 1'b1;
      tick();
    end
    checks++;
    if (rd_cnt_isa !== 10'd10) begin
      errors++;
      $display("FAIL rst_mid pre got cnt=%0d exp 10", rd_cnt_isa);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ddr_bus.ddr_rd_req !== 1'b0 || ddr_bus.ddr_rd_addr !== '0 || ddr_bus.ddr_rd_len !== '0 ||
        instruction_to_cache !== '0 || rd_cnt_isa !== '0 || rd_burst_data_valid !== 1'b0 ||
        isa_read_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async got req=%b addr=%0h len=%0d instr=%0h cnt=%0d stb=%b done=%b exp all 0",
               ddr_bus.ddr_rd_req, ddr_bus.ddr_rd_addr, ddr_bus.ddr_rd_len, instruction_to_cache,
               rd_cnt_isa, rd_burst_data_valid, isa_read_done);
    end
    ISA_read_req = 1'b0;
    tick();
    rst = 1'b1;
    sc = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      ddr_bus.ddr_rd_data = {$urandom, $urandom};
      ddr_bus.ddr_rd_data_valid = 1'b1;
      ddr_bus.ddr_rd_finish = (i == 5);
      tick();
    end
    bus_idle();
    tick();
    checks++;
    if (strobe_cnt !== sc || rd_cnt_isa !== '0 || ddr_bus.ddr_rd_req !== 1'b0 || isa_read_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid stray got strobes=%0d cnt=%0d req=%b done=%b exp strobes=0 cnt=0 req=0 done=0",
               strobe_cnt - sc, rd_cnt_isa, ddr_bus.ddr_rd_req, isa_read_done);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int n;
    bit drop;
    for (int t = 0; t < 10; t++) begin
      a = AW'($urandom);
      a[2:0] = 3'b0;
      n = $urandom_range(1, 200);
      drop = ($urandom_range(0, 3) == 0);
      run_txn(a, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), drop, 20, "random");
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_single();
    test_multi_burst();
    test_ack_delay();
    test_same_cycle();
    test_overrun();
    test_len0();
    test_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_ddr_reader.md
ISA_DDR_READER -- requirements
Module: isa_ddr_reader

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28: byte address width toward the DDR controller.
REQ-002 SHALL have parameter DDR_DATA_WIDTH, default 64: DDR beat width; one instruction per beat.
REQ-003 SHALL have parameter ISA_WIDTH, default 30: instruction width, at most DDR_DATA_WIDTH.
REQ-004 SHALL have parameter MAX_BURST, default 64: maximum beats per DDR burst, range 1..1023.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-006 clk  input  1  system clock, all logic on the rising edge.
REQ-007 rst  input  1  asynchronous reset, active low.
REQ-008 ISA_read_req  input  1  level fetch request from the instruction cache.
REQ-009 ISA_read_addr  input  DDR_ADDR_WIDTH  byte start address, 8-byte aligned.
REQ-010 isa_read_len  input  10  number of instructions to fetch.
REQ-011 instruction_to_cache  output  ISA_WIDTH  fetched instruction.
REQ-012 rd_cnt_isa  output  10  number of instructions delivered in the current transaction.
REQ-013 rd_burst_data_valid  output  1  one-cycle strobe marking each new instruction.
REQ-014 isa_read_done  output  1  transaction complete.
REQ-015 ddr_rd_req  output  1  burst request to the DDR controller.
REQ-016 ddr_rd_addr  output  DDR_ADDR_WIDTH  burst start byte address.
REQ-017 ddr_rd_len  output  10  burst length in beats.
REQ-018 ddr_rd_ack  input  1  burst request accepted.
REQ-019 ddr_rd_data  input  DDR_DATA_WIDTH  read beat data.
REQ-020 ddr_rd_data_valid  input  1  read beat valid.
REQ-021 ddr_rd_finish  input  1  one-cycle pulse marking the end of the burst.

Function
REQ-022 The FSM SHALL have four states, IDLE, REQ, DATA and DONE, and SHALL reset to IDLE.
REQ-023 IDLE: when ISA_read_req=1, the block SHALL latch the address and length, clear rd_cnt_isa to 0 and set remaining to the length.
- Next state SHALL be REQ if length>0, otherwise DONE.
REQ-024 REQ: the block SHALL drive ddr_rd_req=1, ddr_rd_addr=current address and ddr_rd_len=min(remaining, MAX_BURST).
- These values SHALL be held stable until ddr_rd_ack=1 is sampled.
- In the ack cycle the block SHALL drop ddr_rd_req, then move to DATA.
REQ-025 DATA: on each ddr_rd_data_valid=1 cycle the block SHALL register the beat on the next edge.
- instruction_to_cache SHALL take ddr_rd_data[ISA_WIDTH-1:0].
- rd_burst_data_valid SHALL pulse for 1 cycle.
- rd_cnt_isa SHALL increment by 1 on the same edge.
- Latency from beat to strobe SHALL be 1 cycle.
REQ-026 Beats arriving after rd_cnt_isa has reached the latched length SHALL be discarded, with no strobe and no increment.
REQ-027 On ddr_rd_finish in DATA, the block SHALL compute remaining -= the burst length and address += burst length × (DDR_DATA_WIDTH/8).
- Next state SHALL be REQ if remaining>0 and ISA_read_req=1, otherwise DONE.
REQ-028 When ddr_rd_data_valid and ddr_rd_finish are high in the same cycle, the beat SHALL be counted before the finish is evaluated.
REQ-029 ISA_read_req falling during REQ before ack: the block SHALL still complete the handshake and the burst, then go to DONE.
REQ-030 ISA_read_req falling during DATA: the block SHALL drain the outstanding burst, then go to DONE without issuing a further burst.
REQ-031 DONE: the block SHALL hold isa_read_done=1 and hold rd_cnt_isa and instruction_to_cache.
- It SHALL return to IDLE when ISA_read_req=0.
- A request still high in DONE SHALL NOT restart a transaction.
REQ-032 rd_cnt_isa SHALL hold its value in IDLE until the next accepted request.
REQ-033 Address arithmetic SHALL wrap modulo 2^DDR_ADDR_WIDTH.

Reset
REQ-034 With rst=0, all outputs SHALL be 0: ddr_rd_req, ddr_rd_addr, ddr_rd_len, instruction_to_cache, rd_cnt_isa, rd_burst_data_valid and isa_read_done.
- The state SHALL be IDLE.
- Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-035 Reset asserted mid-burst SHALL abandon the transaction.
- After release, the block SHALL ignore DDR data and finish until a new request has been accepted.

Structure
REQ-036 The parameter defaults and the FSM state encodings (IDLE=0, REQ=1, DATA=2, DONE=3) SHALL live in the shared AP defines header used by the instruction cache and the DDR interface.
REQ-037 The block SHALL be a single module with no sub-module; the burst-length min() SHALL be inline logic.

Verification
REQ-038 len=5, addr=0x40 -> one burst with ddr_rd_addr=0x40 and ddr_rd_len=5; 5 strobes; rd_cnt_isa=5; isa_read_done=1.
REQ-039 len=128, MAX_BURST=64, addr=0 -> bursts at 0x000 and 0x200, each of length 64; rd_cnt_isa ends at 128.
REQ-040 ack delayed 7 cycles -> ddr_rd_req, address and length held stable for all 7 cycles; ddr_rd_req drops after the ack cycle.
REQ-041 valid and finish in the same cycle on the last beat -> that beat is counted; rd_cnt_isa=len; exactly one strobe.
REQ-042 len=0 -> no ddr_rd_req; isa_read_done=1 the cycle after the request; return to IDLE when the request drops.
REQ-043 rst pulsed low mid-DATA for len=64 -> all outputs 0 immediately; stray beats after release produce no strobe.
